// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared types and sequence helpers for the JTAG initiator.
//   jtag_op_e     command opcodes as carried on cmd_op
//   jtag_state_e  sequencer FSM states
//   step helpers  TMS value / shift-window test for step s of an operation
package jtag_host_pkg;

  typedef enum logic [1:0] {
    JTAG_TLR  = 2'b00,
    JTAG_IR   = 2'b01,
    JTAG_DR   = 2'b10,
    JTAG_IDLE = 2'b11
  } jtag_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } jtag_state_e;

  localparam int unsigned TLR_LEN  = 6;  // TMS 1,1,1,1,1,0
  localparam int unsigned TLR_ONES = 5;  // leading TMS=1 steps, also TRST-low span
  localparam int unsigned IR_PRE   = 4;  // Select-DR, Select-IR, Capture-IR, Shift-IR
  localparam int unsigned DR_PRE   = 3;  // Select-DR, Capture-DR, Shift-DR
  localparam int unsigned POST_LEN = 2;  // Update, Run-Test/Idle

  function automatic int unsigned pre_len(input jtag_op_e op);
    case (op)
      JTAG_IR: return IR_PRE;
      JTAG_DR: return DR_PRE;
      default: return 0;
    endcase
  endfunction

  // Total TCK count of an operation; len is already clamped.
  function automatic int unsigned total_steps(input jtag_op_e op, input int unsigned len);
    case (op)
      JTAG_TLR:  return TLR_LEN;
      JTAG_IDLE: return len;
      default:   return (len == 0) ? 0 : pre_len(op) + len + POST_LEN;
    endcase
  endfunction

  function automatic logic step_is_shift(input jtag_op_e op, input int unsigned s,
                                         input int unsigned len);
    if (op != JTAG_IR && op != JTAG_DR) return 1'b0;
    return (s >= pre_len(op)) && (s < pre_len(op) + len);
  endfunction

  // IR prologue is 1,1,0,0 and DR prologue 1,0,0: the leading ones are pre-2.
  function automatic logic step_tms(input jtag_op_e op, input int unsigned s,
                                    input int unsigned len);
    int unsigned pre;
    pre = pre_len(op);
    case (op)
      JTAG_TLR:  return s < TLR_ONES;
      JTAG_IDLE: return 1'b0;
      default: begin
        if (s < pre)            return s < pre - 2;
        else if (s < pre + len) return s == pre + len - 1;
        else                    return s == pre + len;
      end
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider. While en is high, tck toggles every CLK_DIV clk
// cycles starting with a low phase; when en is low, tck is held low and the
// phase counter is cleared.
//   clk, reset_n  system clock, async active-low reset
//   en            run the divider
//   tck           divided clock
//   tck_rise      high in the clk cycle whose edge drives tck high
//   tck_fall      high in the clk cycle whose edge drives tck low
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  assign phase_end = en && (cnt == CNT_LAST);
  assign tck_rise  = phase_end && !tck;
  assign tck_fall  = phase_end && tck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (phase_end) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/jtag_host.sv
// jtag_host: bus-side JTAG initiator. Accepts one command at a time, walks the
// TMS/TDI sequence for it at the divided TCK rate and returns one response with
// the TDO bits captured during the shift window.
//   clk, reset_n           system clock, async active-low reset
//   cmd_valid/ready        command handshake; cmd_op, cmd_len, cmd_data payload
//   rsp_valid/ready        response handshake; rsp_data captured TDO bits
//   tck, tms, tdi, trst    TAP drive pins (trst active-low); tdo from the TAP
//   busy                   command accepted and response not yet consumed
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo,
  output logic               busy
);

  localparam int unsigned STEP_W = $clog2(MAX_LEN + TLR_LEN + 2);
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  jtag_state_e        state;
  jtag_op_e           op;
  logic [STEP_W-1:0]  len;
  logic [STEP_W-1:0]  nsteps;
  logic [STEP_W-1:0]  step;
  logic [STEP_W-1:0]  step_nxt;
  logic [MAX_LEN-1:0] data_sr;
  logic [IDX_W-1:0]   cap_idx;
  int unsigned        len_in;
  int unsigned        total;
  logic               tck_rise;
  logic               tck_fall;

  always_comb begin
    len_in = (32'(cmd_len) > MAX_LEN) ? MAX_LEN : 32'(cmd_len);
    total  = total_steps(op, 32'(len));
  end

  assign step_nxt = step + STEP_W'(1);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state == ST_RUN),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= JTAG_TLR;
      len       <= '0;
      nsteps    <= '0;
      step      <= '0;
      data_sr   <= '0;
      cap_idx   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      trst      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          trst <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            op        <= jtag_op_e'(cmd_op);
            len       <= STEP_W'(len_in);
            data_sr   <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        // One set-up cycle: presents step 0 on TMS ahead of the first low
        // phase and accounts for the +1 in the response latency.
        ST_LOAD: begin
          step     <= '0;
          cap_idx  <= '0;
          rsp_data <= '0;
          nsteps   <= STEP_W'(total);
          tdi      <= 1'b0;
          if (total == 0) begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tms   <= step_tms(op, 0, 32'(len));
            trst  <= (op != JTAG_TLR);
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (tck_rise && step_is_shift(op, 32'(step), 32'(len))) begin
            rsp_data[cap_idx] <= tdo;
            cap_idx           <= cap_idx + IDX_W'(1);
          end
          if (tck_fall) begin
            if (step == nsteps - STEP_W'(1)) begin
              tdi       <= 1'b0;
              trst      <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              step <= step_nxt;
              tms  <= step_tms(op, 32'(step_nxt), 32'(len));
              trst <= !(op == JTAG_TLR && 32'(step_nxt) < TLR_ONES);
              if (step_is_shift(op, 32'(step_nxt), 32'(len))) begin
                tdi     <= data_sr[0];
                data_sr <= data_sr >> 1;
              end else begin
                tdi <= 1'b0;
              end
            end
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
